// File: rtl/uart_loader.sv
// UART frame loader: receives 3-byte frames {hdr, hi, lo} and presents 16-bit words.
// Optional even parity per byte is enabled by defining UART_LOADER_PARITY_EN.
module uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int GAP_BITS     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        uart_en,
    output logic [1:0]  uart_sel,
    output logic [15:0] uart_data,
    output logic        frame_err,
    output logic        busy
);

    localparam int BAUD_W    = $clog2(CLKS_PER_BIT + 1);
    localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
    localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_LIMIT - 1);
    localparam logic [5:0]        HDR_TAG   = 6'b101001;

    typedef enum logic [2:0] {
        IDLE, START, DATA,
`ifdef UART_LOADER_PARITY_EN
        PARITY,
`endif
        STOP
    } rx_state_t;

    typedef enum logic [1:0] {HDR, HI, LO} asm_state_t;

    logic              meta_q, sync_q;
    rx_state_t         rx_state_q, rx_state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    asm_state_t        asm_state_q, asm_state_d;
    logic [1:0]        sel_q, sel_d;
    logic [7:0]        hi_q, hi_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              uart_en_q, uart_en_d;
    logic [1:0]        uart_sel_q, uart_sel_d;
    logic [15:0]       uart_data_q, uart_data_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;
    logic              byte_ok_s, byte_bad_s, gap_timeout_s;
    logic              par_err_s;
`ifdef UART_LOADER_PARITY_EN
    logic              par_err_q, par_err_d;
    assign par_err_s = par_err_q;
`else
    assign par_err_s = 1'b0;
`endif

    // Byte receiver: mid-bit sampling driven by a single baud counter
    always_comb begin
        rx_state_d = rx_state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_ok_s  = 1'b0;
        byte_bad_s = 1'b0;
`ifdef UART_LOADER_PARITY_EN
        par_err_d  = par_err_q;
`endif
        case (rx_state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = 3'd0;
                if (!sync_q) begin
                    rx_state_d = START;
                end else begin
                    rx_state_d = IDLE;
                end
            end
            START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d     = '0;
                    rx_state_d = sync_q ? IDLE : DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_LOADER_PARITY_EN
                        rx_state_d = PARITY;
`else
                        rx_state_d = STOP;
`endif
                    end else begin
                        rx_state_d = DATA;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_LOADER_PARITY_EN
            PARITY: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d     = '0;
                    par_err_d  = sync_q ^ (^shift_q);
                    rx_state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d     = '0;
                    rx_state_d = IDLE;
                    if (sync_q && !par_err_s) begin
                        byte_ok_s = 1'b1;
                    end else begin
                        byte_bad_s = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                rx_state_d = IDLE;
                baud_d     = '0;
            end
        endcase
    end

    // Frame assembler and inter-byte gap supervision; a delivered byte beats a timeout
    always_comb begin
        asm_state_d   = asm_state_q;
        sel_d         = sel_q;
        hi_d          = hi_q;
        uart_en_d     = 1'b0;
        uart_sel_d    = uart_sel_q;
        uart_data_d   = uart_data_q;
        frame_err_d   = 1'b0;
        gap_timeout_s = (asm_state_q != HDR) && (rx_state_q == IDLE) && (gap_q == GAP_LAST);
        if ((asm_state_q != HDR) && (rx_state_q == IDLE) && (rx_state_d == IDLE)) begin
            gap_d = gap_q + 1'b1;
        end else begin
            gap_d = '0;
        end
        if (byte_bad_s) begin
            frame_err_d = 1'b1;
            asm_state_d = HDR;
        end else if (byte_ok_s) begin
            case (asm_state_q)
                HDR: begin
                    if (shift_q[7:2] == HDR_TAG) begin
                        sel_d       = shift_q[1:0];
                        asm_state_d = HI;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                HI: begin
                    hi_d        = shift_q;
                    asm_state_d = LO;
                end
                LO: begin
                    uart_en_d   = 1'b1;
                    uart_sel_d  = sel_q;
                    uart_data_d = {hi_q, shift_q};
                    asm_state_d = HDR;
                end
                default: asm_state_d = HDR;
            endcase
        end else if (gap_timeout_s) begin
            frame_err_d = 1'b1;
            asm_state_d = HDR;
        end else begin
            asm_state_d = asm_state_q;
        end
        if (asm_state_d != asm_state_q) begin
            gap_d = '0;
        end else begin
            gap_d = gap_d;
        end
        busy_d = (asm_state_d != HDR);
    end

    // State, counters, synchronizer and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q      <= 1'b1;
            sync_q      <= 1'b1;
            rx_state_q  <= IDLE;
            baud_q      <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            asm_state_q <= HDR;
            sel_q       <= 2'b00;
            hi_q        <= 8'h00;
            gap_q       <= '0;
            uart_en_q   <= 1'b0;
            uart_sel_q  <= 2'b00;
            uart_data_q <= 16'h0000;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_LOADER_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            meta_q      <= rx;
            sync_q      <= meta_q;
            rx_state_q  <= rx_state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            asm_state_q <= asm_state_d;
            sel_q       <= sel_d;
            hi_q        <= hi_d;
            gap_q       <= gap_d;
            uart_en_q   <= uart_en_d;
            uart_sel_q  <= uart_sel_d;
            uart_data_q <= uart_data_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
`ifdef UART_LOADER_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign uart_en   = uart_en_q;
    assign uart_sel  = uart_sel_q;
    assign uart_data = uart_data_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed + randomized bench for uart_loader, checked against a byte-level frame model.
module tb_uart_loader;

    localparam int CLKS = 16;
    localparam int GAP  = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic        uart_en;
    logic [1:0]  uart_sel;
    logic [15:0] uart_data;
    logic        frame_err;
    logic        busy;

    uart_loader #(.CLKS_PER_BIT(CLKS), .GAP_BITS(GAP)) dut (
        .clk(clk), .reset(reset), .rx(rx), .uart_en(uart_en), .uart_sel(uart_sel),
        .uart_data(uart_data), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state (frame-level)
    int          m_state = 0;   // bytes of current frame already accepted
    logic [1:0]  m_sel = 2'b00;
    logic [7:0]  m_hi = 8'h00;
    logic [17:0] m_last = 18'h0;
    logic [17:0] exp_q[$];
    int          exp_err = 0;

    logic [17:0] got_q[$];
    int          got_err = 0;
    logic        en_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (uart_en) begin
            got_q.push_back({uart_sel, uart_data});
            check("en_one_cycle", {31'd0, en_prev}, 32'd0);
        end
        if (frame_err) got_err <= got_err + 1;
        en_prev <= uart_en;
    end

    task automatic model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            exp_err++;
            m_state = 0;
        end else if (m_state == 0) begin
            if (b[7:2] == 6'b101001) begin
                m_sel = b[1:0];
                m_state = 1;
            end else begin
                exp_err++;
            end
        end else if (m_state == 1) begin
            m_hi = b;
            m_state = 2;
        end else begin
            m_last = {m_sel, m_hi, b};
            exp_q.push_back(m_last);
            m_state = 0;
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1, input bit par_ok = 1'b1);
        hold(1'b0, CLKS);
        for (int i = 0; i < 8; i++) hold(b[i], CLKS);
`ifdef UART_LOADER_PARITY_EN
        hold((^b) ^ !par_ok, CLKS);
`endif
        if (stop_ok) begin
            hold(1'b1, CLKS);
        end else begin
            hold(1'b0, CLKS / 2 + 3);
            hold(1'b1, CLKS - CLKS / 2 - 3);
        end
`ifdef UART_LOADER_PARITY_EN
        model_byte(b, stop_ok && par_ok);
`else
        model_byte(b, stop_ok);
`endif
    endtask

    task automatic idle(input int n);
        hold(1'b1, n * CLKS);
        if (m_state != 0 && n >= GAP) begin
            exp_err++;
            m_state = 0;
        end
    endtask

    task automatic check_all(input string tag);
        repeat (4) @(negedge clk);
        check({tag, "_en_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_word"}, {14'd0, got_q[i]}, {14'd0, exp_q[i]});
        check({tag, "_err_count"}, got_err, exp_err);
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, (m_state != 0)});
        check({tag, "_held"}, {14'd0, uart_sel, uart_data}, {14'd0, m_last});
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("rst_en", {31'd0, uart_en}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out", {14'd0, uart_sel, uart_data}, 32'd0);
        reset = 1'b1;
        idle(2);

        // basic frame
        send_byte(8'hA7); send_byte(8'h12); send_byte(8'h34);
        idle(2); check_all("basic");

        // back-to-back frames, zero idle
        send_byte(8'hA5); send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'hA7); send_byte(8'h00); send_byte(8'h01);
        idle(2); check_all("b2b");

        // bad header then good frame
        send_byte(8'h55);
        send_byte(8'hA6); send_byte(8'hAA); send_byte(8'h55);
        idle(2); check_all("badhdr");

        // gap timeout
        send_byte(8'hA7); send_byte(8'h12);
        check_all("gap_mid");
        idle(GAP + 1); check_all("gap_to");
        send_byte(8'h34);
        idle(2); check_all("gap_after");

        // stop bit forced low, then a short glitch
        send_byte(8'hA7, 1'b0);
        idle(1); check_all("stop0");
        hold(1'b0, (CLKS * 3) / 10);
        idle(2); check_all("glitch");

        // reset mid-HI byte
        send_byte(8'hA7);
        hold(1'b0, CLKS);
        hold(1'b0, CLKS); hold(1'b1, CLKS); hold(1'b0, CLKS);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_out", {14'd0, uart_sel, uart_data}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_err", got_err, exp_err);
        rx = 1'b1;
        reset = 1'b1;
        m_state = 0;
        m_last = 18'h0;
        idle(2);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'hFF);
        idle(2); check_all("after_rst");

`ifdef UART_LOADER_PARITY_EN
        send_byte(8'hA5); send_byte(8'h12, 1'b1, 1'b0);
        idle(2); check_all("parity");
`endif

        // randomized frames
        for (int f = 0; f < 12; f++) begin
            logic [7:0] b;
            for (int k = 0; k < 3; k++) begin
                bit sok;
                bit pok;
                if (k == 0 && $urandom_range(0, 4) != 0)
                    b = {6'b101001, 2'($urandom_range(0, 3))};
                else
                    b = 8'($urandom_range(0, 255));
                sok = ($urandom_range(0, 9) != 0);
                pok = ($urandom_range(0, 9) != 0);
                send_byte(b, sok, pok);
                if (!sok) idle(1 + $urandom_range(0, 1));
                else idle($urandom_range(0, 2));
            end
        end
        idle(GAP + 2);
        check_all("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per serial bit (minimum 4).
REQ-002 The block SHALL have parameter GAP_BITS, default 32, the maximum idle bit-times allowed between bytes of one frame.
REQ-003 The block SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 The block SHALL have port uart_en  output  1  one-cycle pulse: uart_sel/uart_data hold a new word.
REQ-007 The block SHALL have port uart_sel  output  2  target select from the frame header (3 = instruction memory, 1 = data memory, others passed through).
REQ-008 The block SHALL have port uart_data  output  16  word payload.
REQ-009 The block SHALL have port frame_err  output  1  one-cycle pulse on any discarded byte or frame.
REQ-010 The block SHALL have port busy  output  1  high while a frame is partially received.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all decoding SHALL use the synchronized value.
REQ-012 The byte receiver FSM SHALL have states IDLE, START, DATA, PARITY (only when UART_LOADER_PARITY_EN is defined), and STOP.
REQ-013 IDLE->START SHALL occur on the first synchronized low; in START, a low resample at CLKS_PER_BIT/2 SHALL go to DATA, otherwise the FSM SHALL return to IDLE silently as a glitch.
REQ-014 DATA SHALL sample 8 bits LSB-first, each CLKS_PER_BIT cycles after the previous sample point (mid-bit).
REQ-015 STOP sampled 1 SHALL deliver the byte to the assembler; STOP sampled 0 SHALL discard the byte, pulse frame_err, and return the assembler to HDR.
REQ-016 The frame SHALL consist of 3 bytes: header {6'b101001, sel[1:0]}, data[15:8], data[7:0].
REQ-017 The assembler FSM SHALL have states HDR, HI, and LO.
REQ-018 In HDR, a byte with upper 6 bits != 6'b101001 SHALL be dropped with a frame_err pulse, and the assembler SHALL stay in HDR.
REQ-019 When the LO byte is accepted, uart_sel and uart_data SHALL update and uart_en SHALL pulse for exactly 1 cycle, on the cycle after the LO stop-bit sample; the outputs SHALL then hold until the next valid frame.
REQ-020 busy SHALL be 1 in HI and LO and 0 in HDR.
REQ-021 A gap counter SHALL run in HI/LO while the receiver is IDLE; reaching GAP_BITS*CLKS_PER_BIT cycles SHALL force HDR and pulse frame_err.
REQ-022 When a byte delivery and a gap timeout occur in the same cycle, the byte SHALL win and the timeout SHALL be ignored.
REQ-023 Back-to-back frames with zero idle between the stop bit and the next start bit SHALL be received without loss.
REQ-024 The baud and gap counters SHALL never wrap; each SHALL clear on every state transition.

Reset
REQ-025 While reset is 0 at a clk edge: both FSMs SHALL go to IDLE/HDR, all counters to 0, synchronizer flops to 1, uart_en=0, uart_sel=2'b00, uart_data=16'h0000, frame_err=0, busy=0.
REQ-026 Reset asserted mid-byte or mid-frame SHALL abandon that data with no uart_en or frame_err pulse; reception SHALL restart on the next start bit after release.

Configuration
REQ-027 With UART_LOADER_PARITY_EN defined, each byte SHALL carry an even-parity bit after bit 7; a mismatch SHALL discard the byte, pulse frame_err, and return the assembler to HDR.
REQ-028 Without UART_LOADER_PARITY_EN, the format SHALL be 8N1, the PARITY state SHALL not exist, and no parity logic SHALL be synthesized.

Verification
REQ-029 Bench with CLKS_PER_BIT=16: send bytes A7,12,34 -> one uart_en pulse with uart_sel=3 and uart_data=16'h1234; frame_err stays 0.
REQ-030 Send A5,BE,EF, then immediately A7,00,01 with no idle -> two pulses: (sel=1, data=16'hBEEF) then (sel=3, data=16'h0001).
REQ-031 Send header 55 -> frame_err pulses, no uart_en; a following A6,AA,55 -> uart_en with sel=2 and data=16'hAA55.
REQ-032 Send A7,12, then idle 33 bit-times, then 34 -> frame_err at timeout, no uart_en; busy returns to 0.
REQ-033 Send A7 with stop bit forced 0 -> frame_err, assembler in HDR; a 0.3-bit low glitch on rx -> no activity.
REQ-034 Assert reset mid-HI byte -> outputs return to their reset values with no pulses; a subsequent A5,00,FF -> sel=1, data=16'h00FF; with UART_LOADER_PARITY_EN defined, a wrong parity bit on byte 2 -> frame_err and no uart_en.
